// File: rtl/uart_apb_master.sv
// UART-driven APB initiator. Parses CMD/ADDR/DATA frames from the UART
// receive byte stream, runs one APB read or write per frame and sends a
// status byte (plus read data for reads) back through the UART transmitter.
module uart_apb_master #(
    parameter int TIMEOUT_CYCLES = 1_000_000,  // inter-byte gap limit, must be >= 2
    parameter int PREADY_TIMEOUT = 255         // ACCESS-phase limit, must be >= 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_done,
    output logic [4:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        frame_err
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = (PREADY_TIMEOUT > 1) ? $clog2(PREADY_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ACC_LAST = AW'(PREADY_TIMEOUT - 1);

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
    localparam logic [7:0] RSP_UNK = 8'h3F;  // '?'

    typedef enum logic [3:0] {
        IDLE, ADDR, DATA0, DATA1, DATA2, DATA3,
        SETUP, ACCESS, RESP, RESP_WAIT
    } state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;    // cycles since the last frame byte, counting the current one
    logic [AW-1:0]  acc_cnt;    // ACCESS cycles already spent without pready
    logic [31:0]    resp_buf;   // read data still to be sent, LSB first
    logic [2:0]     resp_left;  // bytes still to send after the current one
    logic           apb_ok;

    assign apb_ok = pready & ~pslverr;
    assign busy   = (state != IDLE);

    // Frame parser, APB sequencer and response sequencer in one registered FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            acc_cnt   <= '0;
            resp_buf  <= '0;
            resp_left <= '0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            frame_err <= 1'b0;
        end else begin
            tx_send   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            pwrite  <= (rx_data == CMD_WR);
                            gap_cnt <= GW'(1);
                            state   <= ADDR;
                        end else begin
                            // Unknown command: drop it and answer '?'
                            frame_err <= 1'b1;
                            tx_data   <= RSP_UNK;
                            tx_send   <= 1'b1;
                            resp_left <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ADDR, DATA0, DATA1, DATA2, DATA3: begin
                    if (rx_err) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (rx_valid) begin
                        gap_cnt <= GW'(1);
                        if (state == ADDR) paddr <= rx_data[4:0];
                        else               pwdata <= {rx_data, pwdata[31:8]};  // LSB arrives first
                        psel <= (state == DATA3) || (state == ADDR && !pwrite);
                        case (state)
                            ADDR:    state <= pwrite ? DATA0 : SETUP;
                            DATA0:   state <= DATA1;
                            DATA1:   state <= DATA2;
                            DATA2:   state <= DATA3;
                            default: state <= SETUP;
                        endcase
                    end else if (gap_cnt == GAP_LAST) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    acc_cnt <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Completion or abort; a missing pready counts as an error
                    if (pready || acc_cnt == ACC_LAST) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        tx_data   <= apb_ok ? RSP_OK : RSP_ERR;
                        tx_send   <= 1'b1;
                        resp_buf  <= apb_ok ? prdata : 32'h0;
                        resp_left <= pwrite ? 3'd0 : 3'd4;
                        state     <= RESP;
                    end else begin
                        acc_cnt <= acc_cnt + AW'(1);
                    end
                end
                RESP: begin
                    state <= RESP_WAIT;
                end
                RESP_WAIT: begin
                    if (tx_done) begin
                        if (resp_left != 3'd0) begin
                            tx_data   <= resp_buf[7:0];
                            resp_buf  <= {8'h00, resp_buf[31:8]};
                            resp_left <= resp_left - 3'd1;
                            tx_send   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
